// File: rtl/even_sched_pkg.sv
// Shared types for the even-pipe issue scheduler: request classes, unit latencies and
// the reservation-slot record.
package even_sched_pkg;

    localparam logic [2:0] SF1_LAT  = 3'd2;
    localparam logic [2:0] SF2_LAT  = 3'd3;
    localparam logic [2:0] BYTE_LAT = 3'd3;
    localparam logic [2:0] FP6_LAT  = 3'd6;
    localparam logic [2:0] FP7_LAT  = 3'd7;

    typedef enum logic [2:0] {
        CLS_SF1  = 3'd0,
        CLS_SF2  = 3'd1,
        CLS_BYTE = 3'd2,
        CLS_FP6  = 3'd3,
        CLS_FP7  = 3'd4
    } req_class_e;

    typedef struct packed {
        logic       valid;
        logic [0:6] rt;
    } resv_slot_t;

    // Encodings 5-7 map to latency 0, which the top treats as illegal.
    function automatic logic [2:0] class_lat(input req_class_e c);
        case (c)
            CLS_SF1:  class_lat = SF1_LAT;
            CLS_SF2:  class_lat = SF2_LAT;
            CLS_BYTE: class_lat = BYTE_LAT;
            CLS_FP6:  class_lat = FP6_LAT;
            CLS_FP7:  class_lat = FP7_LAT;
            default:  class_lat = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/even_resv_table.sv
// Reservation table of in-flight even-pipe writers; slot i holds the result that reaches
// write-back in i cycles. Shifts down every cycle and exposes per-slot match vectors.
module even_resv_table
    import even_sched_pkg::*;
#(
    parameter int MAX_LAT = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               ins_en,
    input  logic [2:0]         ins_idx,
    input  logic [6:0]         ins_rt,
    input  logic [6:0]         q_rt,
    input  logic [6:0]         q_ra,
    input  logic [6:0]         q_rb,
    input  logic [6:0]         q_rc,
    output logic [MAX_LAT-1:1] slot_valid,
    output logic [MAX_LAT-1:1] rt_hit,
    output logic [MAX_LAT-1:1] ra_hit,
    output logic [MAX_LAT-1:1] rb_hit,
    output logic [MAX_LAT-1:1] rc_hit
);

    resv_slot_t slots [1:MAX_LAT-1];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int i = 1; i < MAX_LAT; i++) slots[i] <= '0;
        end else begin
            for (int i = 1; i < MAX_LAT - 1; i++) slots[i] <= slots[i+1];
            slots[MAX_LAT-1] <= '0;
            // Insert lands after the shift, so the new entry is not moved this edge.
            for (int i = 1; i < MAX_LAT; i++) begin
                if (ins_en && (int'(ins_idx) == i)) slots[i] <= '{valid: 1'b1, rt: ins_rt};
            end
        end
    end

    always_comb begin
        slot_valid = '0;
        rt_hit     = '0;
        ra_hit     = '0;
        rb_hit     = '0;
        rc_hit     = '0;
        for (int i = 1; i < MAX_LAT; i++) begin
            slot_valid[i] = slots[i].valid;
            rt_hit[i]     = slots[i].valid && (slots[i].rt == q_rt);
            ra_hit[i]     = slots[i].valid && (slots[i].rt == q_ra);
            rb_hit[i]     = slots[i].valid && (slots[i].rt == q_rb);
            rc_hit[i]     = slots[i].valid && (slots[i].rt == q_rc);
        end
    end

endmodule

// File: rtl/even_issue_sched.sv
// Even-pipe issue scheduler: structural/RAW/WAW hazard checks against the reservation table.
// Optional stall counters are built when EVEN_SCHED_PERF_EN is defined.
module even_issue_sched
    import even_sched_pkg::*;
#(
    parameter int MAX_LAT      = 7,
    parameter int BYPASS_SLACK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_class,
    input  logic        req_wr,
    input  logic [6:0]  req_rt,
    input  logic [6:0]  req_ra,
    input  logic [6:0]  req_rb,
    input  logic [6:0]  req_rc,
    input  logic [2:0]  req_use,
    output logic        issue_valid,
    output logic [2:0]  issue_lat,
    output logic        busy,
    output logic [31:0] struct_stalls,
    output logic [31:0] raw_stalls
);

    // Handshake: an instruction issues on a cycle where req_valid & req_ready; req_ready is a
    // pure function of table state and the offered request and never depends on req_valid.
    logic [MAX_LAT-1:1] slot_valid, rt_hit, ra_hit, rb_hit, rc_hit;
    logic [2:0]         lat;
    logic               class_legal, structural, raw, waw, grant;

    even_resv_table #(.MAX_LAT(MAX_LAT)) u_table (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .ins_en     (grant && req_wr),
        .ins_idx    (lat - 3'd1),
        .ins_rt     (req_rt),
        .q_rt       (req_rt),
        .q_ra       (req_ra),
        .q_rb       (req_rb),
        .q_rc       (req_rc),
        .slot_valid (slot_valid),
        .rt_hit     (rt_hit),
        .ra_hit     (ra_hit),
        .rb_hit     (rb_hit),
        .rc_hit     (rc_hit)
    );

    always_comb begin
        lat         = class_lat(req_class_e'(req_class));
        class_legal = (req_class <= 3'd4);
        structural  = 1'b0;
        raw         = 1'b0;
        waw         = 1'b0;
        for (int i = 1; i < MAX_LAT; i++) begin
            if (req_wr && (int'(lat) == i) && slot_valid[i]) structural = 1'b1;
            if ((i > BYPASS_SLACK) && ((req_use[2] && ra_hit[i]) || (req_use[1] && rb_hit[i]) ||
                                       (req_use[0] && rc_hit[i]))) raw = 1'b1;
            if (req_wr && (i >= int'(lat)) && rt_hit[i]) waw = 1'b1;
        end
        req_ready = reset && !flush && class_legal && !structural && !raw && !waw;
        grant     = req_valid && req_ready;
        busy      = |slot_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_valid <= 1'b0;
            issue_lat   <= 3'd0;
        end else begin
            issue_valid <= grant;
            issue_lat   <= grant ? lat : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && req_valid) illegal_class_a: assert (class_legal);
    end

`ifdef EVEN_SCHED_PERF_EN
    logic [31:0] struct_cnt, raw_cnt;

    // Structural wins attribution; flush does not clear history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            struct_cnt <= '0;
            raw_cnt    <= '0;
        end else begin
            if (req_valid && structural && (struct_cnt != 32'hFFFF_FFFF))
                struct_cnt <= struct_cnt + 32'd1;
            if (req_valid && (raw || waw) && !structural && (raw_cnt != 32'hFFFF_FFFF))
                raw_cnt <= raw_cnt + 32'd1;
        end
    end

    assign struct_stalls = struct_cnt;
    assign raw_stalls    = raw_cnt;
`else
    assign struct_stalls = 32'd0;
    assign raw_stalls    = 32'd0;
`endif

endmodule

// File: tb/tb_even_issue_sched.sv
// Bench for even_issue_sched: directed scenarios then random traffic, checked against a
// model that tracks in-flight writers by absolute write-back cycle.
module tb_even_issue_sched;

`ifdef EVEN_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, req_wr, issue_valid, busy;
    logic [2:0]  req_class, req_use, issue_lat;
    logic [6:0]  req_rt, req_ra, req_rb, req_rc;
    logic [31:0] struct_stalls, raw_stalls;

    even_issue_sched dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_class     (req_class),
        .req_wr        (req_wr),
        .req_rt        (req_rt),
        .req_ra        (req_ra),
        .req_rb        (req_rb),
        .req_rc        (req_rc),
        .req_use       (req_use),
        .issue_valid   (issue_valid),
        .issue_lat     (issue_lat),
        .busy          (busy),
        .struct_stalls (struct_stalls),
        .raw_stalls    (raw_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] rt;
        int         wb;
    } flight_t;

    flight_t     fl[$];
    int          lat_tab[5] = '{2, 3, 3, 6, 7};
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          known = 1'b0;
    logic        exp_iv = 1'b0;
    logic [2:0]  exp_il = 3'd0;
    logic [31:0] exp_sc = 0, exp_rc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic w, input logic [6:0] rt,
                         input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                         input logic [2:0] u);
        req_valid = v; req_class = c; req_wr = w; req_rt = rt;
        req_ra = ra; req_rb = rb; req_rc = rc; req_use = u;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
    endtask

    // One clock: compare at the negedge, advance the model, return 1ns after the posedge.
    task automatic cycle();
        flight_t keep[$];
        int      lat, idx;
        bit      legal, st, rw, ww, m_ready, grant;
        @(negedge clk);
        if (!reset) begin
            check("reset_ready", req_ready, 0);
            fl = {}; exp_iv = 0; exp_il = 0; exp_sc = 0; exp_rc = 0; known = 1'b1;
        end else if (known) begin
            keep = {};
            foreach (fl[k]) if (fl[k].wb > cyc) keep.push_back(fl[k]);
            fl = keep;
            legal = (req_class <= 3'd4);
            lat = legal ? lat_tab[req_class] : 0;
            st = 0; rw = 0; ww = 0;
            foreach (fl[k]) begin
                idx = fl[k].wb - cyc;
                if (req_wr && idx == lat) st = 1;
                if (idx > 1 && ((req_use[2] && req_ra == fl[k].rt) || (req_use[1] && req_rb == fl[k].rt) ||
                                (req_use[0] && req_rc == fl[k].rt))) rw = 1;
                if (req_wr && idx >= lat && req_rt == fl[k].rt) ww = 1;
            end
            m_ready = !flush && legal && !st && !rw && !ww;
            check("req_ready", req_ready, m_ready);
            check("busy", busy, fl.size() != 0);
            check("issue_valid", issue_valid, exp_iv);
            check("issue_lat", issue_lat, exp_il);
            check("struct_stalls", struct_stalls, PERF ? exp_sc : 0);
            check("raw_stalls", raw_stalls, PERF ? exp_rc : 0);
            grant = req_valid && m_ready;
            if (flush) fl = {};
            else if (grant && req_wr) fl.push_back('{rt: req_rt, wb: cyc + lat});
            exp_iv = grant;
            exp_il = grant ? 3'(lat) : 3'd0;
            if (req_valid && st) exp_sc++;
            else if (req_valid && (rw || ww)) exp_rc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        idle();
        // Reset held two cycles, then a plain SF1 is immediately acceptable.
        cycle(); cycle();
        reset = 1'b1;
        drive(1'b1, 3'd0, 1'b1, 7'd1, 7'd0, 7'd0, 7'd0, 3'b000);
        #1; check("t1_ready", req_ready, 1); check("t1_busy", busy, 0); check("t1_iv", issue_valid, 0);
        cycle();
        idle(); repeat (3) cycle();

        // Structural: FP7 rt=5, then SF1 rt=9 collides on write-back 5 cycles later.
        drive(1'b1, 3'd4, 1'b1, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000); cycle();
        idle(); repeat (4) cycle();
        drive(1'b1, 3'd0, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000);
        #1; check("t2_stall", req_ready, 0); cycle();
        #1; check("t2_grant", req_ready, 1); cycle();
        idle(); repeat (8) cycle();

        // RAW: SF2 rt=3 then SF1 reading ra=3.
        drive(1'b1, 3'd1, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000); cycle();
        drive(1'b1, 3'd0, 1'b1, 7'd20, 7'd3, 7'd0, 7'd0, 3'b100);
        #1; check("t3_stall", req_ready, 0); cycle();
        #1; check("t3_grant", req_ready, 1); cycle();
        idle(); repeat (4) cycle();

        // WAW: FP6 rt=4 then SF1 rt=4 held until the model grants it.
        drive(1'b1, 3'd3, 1'b1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000); cycle();
        drive(1'b1, 3'd0, 1'b1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000);
        #1; check("t4_stall", req_ready, 0);
        repeat (5) cycle();
        idle(); repeat (8) cycle();

        // Flush kills the FP7 and blocks the concurrent request.
        drive(1'b1, 3'd4, 1'b1, 7'd7, 7'd0, 7'd0, 7'd0, 3'b000); cycle();
        idle(); cycle();
        flush = 1'b1;
        drive(1'b1, 3'd0, 1'b1, 7'd30, 7'd0, 7'd0, 7'd0, 3'b000);
        #1; check("t5_flush_ready", req_ready, 0); cycle();
        flush = 1'b0;
        drive(1'b1, 3'd0, 1'b1, 7'd31, 7'd7, 7'd0, 7'd0, 3'b100);
        #1; check("t5_busy", busy, 0); check("t5_ready", req_ready, 1); cycle();
        idle(); repeat (4) cycle();

        // Back-to-back independent SF1 writes.
        for (int r = 10; r <= 15; r++) begin
            drive(1'b1, 3'd0, 1'b1, 7'(r), 7'd0, 7'd0, 7'd0, 3'b000);
            #1; check("t6_ready", req_ready, 1); cycle();
        end
        idle(); repeat (4) cycle();

        // Illegal classes are never ready.
        drive(1'b0, 3'd5, 1'b1, 7'd1, 7'd0, 7'd0, 7'd0, 3'b000);
        #1; check("ill5_ready", req_ready, 0); cycle();
        drive(1'b0, 3'd7, 1'b0, 7'd1, 7'd0, 7'd0, 7'd0, 3'b000);
        #1; check("ill7_ready", req_ready, 0); cycle();

        // Random traffic over a small register range to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 4)), 1'($urandom_range(0, 3) != 0),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            flush = ($urandom_range(0, 15) == 0);
            reset = (n == 400) ? 1'b0 : 1'b1;
            cycle();
        end
        flush = 1'b0; reset = 1'b1;
        idle(); repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
